// File: rtl/multiplier_iterative_param_if.sv
// Request/response bundle for the iterative multiplier: operands in, ready/valid_out
// handshake and the 2*WIDTH product out.
interface multiplier_iterative_param_if #(
    parameter int WIDTH = 32
);
    logic               valid_in;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               valid_out;
    logic [2*WIDTH-1:0] r;

    modport master (
        output valid_in, signed_mode, a, b,
        input  ready, valid_out, r
    );

    modport slave (
        input  valid_in, signed_mode, a, b,
        output ready, valid_out, r
    );
endinterface

// File: rtl/multiplier_iterative_param.sv
// Iterative sign-magnitude multiplier, RADIX_BITS multiplier bits per cycle.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier_iterative_param #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    multiplier_iterative_param_if.slave bus
);
    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    generate
        if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
            $error("WIDTH must be a multiple of RADIX_BITS");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [PW-1:0]    mc_q, mc_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             valid_out_q, valid_out_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    partial, acc_next;
    logic [WIDTH-1:0] mp_shift;
    logic             last_iter;

    // The most-negative operand negates to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    always_comb begin
        a_mag    = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag    = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        partial  = mc_q * PW'(mp_q[RADIX_BITS-1:0]);
        acc_next = acc_q + partial;
        mp_shift = mp_q >> RADIX_BITS;
`ifdef MULT_EARLY_TERM_EN
        last_iter = (cnt_q == CNT_W'(N - 1)) || (mp_shift == '0);
`else
        last_iter = (cnt_q == CNT_W'(N - 1));
`endif
    end

    // NOTE: every next-state signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        mp_d        = mp_q;
        mc_d        = mc_q;
        acc_d       = acc_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        valid_out_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    mp_d    = a_mag;
                    mc_d    = PW'(b_mag);
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                mp_d  = mp_shift;
                mc_d  = mc_q << RADIX_BITS;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    r_d         = neg_q ? -acc_next : acc_next;
                    valid_out_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mp_q        <= '0;
            mc_q        <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mp_q        <= mp_d;
            mc_q        <= mc_d;
            acc_q       <= acc_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.valid_out = valid_out_q;
    assign bus.r         = r_q;
endmodule

// File: tb/tb_multiplier_iterative_param.sv
// Scoreboard bench for multiplier_iterative_param: randomized and directed ops checked
// against a plain-arithmetic product/latency model; a second 16-bit, radix-2 instance is swept too.
module tb_multiplier_iterative_param;
  localparam int W = 32;
  localparam int R = 4;
  localparam int N = W / R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplier_iterative_param_if #(.WIDTH(32)) bus32 ();
  multiplier_iterative_param_if #(.WIDTH(16)) bus16 ();

  multiplier_iterative_param #(.WIDTH(32), .RADIX_BITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus32)
  );

  multiplier_iterative_param #(.WIDTH(16), .RADIX_BITS(2)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] r;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference product: ordinary signed or unsigned 64-bit multiplication.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = longint'(a);
    ub = longint'(b);
    return ua * ub;
  endfunction

  // Reference latency in edges from capture to the result edge.
  function automatic int ref_k(input logic [31:0] a, input logic s);
`ifdef MULT_EARLY_TERM_EN
    longint sa;
    longint unsigned mag;
    int bl;
    int k;
    sa  = s ? longint'($signed(a)) : longint'(a);
    mag = (sa < 0) ? longint'(-sa) : longint'(sa);
    bl  = 0;
    while (mag != 0) begin
      bl++;
      mag = mag >> 1;
    end
    k = (bl + R - 1) / R;
    return (k < 1) ? 1 : k;
`else
    return N + 0 * int'(a[0] & s);
`endif
  endfunction

  // Monitor: every valid_out pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus32.valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_out actual=1 required=0 r=%h (t=%0t)", bus32.r, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("product", bus32.r, mon_e.r);
        check("latency_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus32.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 64'(bus32.ready), 64'd1);
    bus32.valid_in    = 1'b1;
    bus32.a           = a;
    bus32.b           = b;
    bus32.signed_mode = s;
    @(posedge clk);
    #1;
    exp_q.push_back('{r: ref_prod(a, b, s), due: cyc + ref_k(a, s)});
    bus32.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] dir_a[8] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'h8000_0000, 32'h8000_0000, 32'd0, 32'h0000_0100};
  logic [31:0] dir_b[8] = '{32'd5, 32'hFFFF_FFFF, 32'd6, 32'd6,
                            32'h8000_0000, 32'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFE};
  logic        dir_s[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  int          bl;
  int          gap;
  int          n16;
  int          cap16;
  logic [31:0] rnd_a, rnd_b, mask;

  initial begin
    bus32.valid_in = 1'b0; bus32.signed_mode = 1'b0; bus32.a = '0; bus32.b = '0;
    bus16.valid_in = 1'b0; bus16.signed_mode = 1'b0; bus16.a = '0; bus16.b = '0;

    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus32.ready), 64'd1);
    check("reset_valid_out", 64'(bus32.valid_out), 64'd0);
    check("reset_r", bus32.r, 64'd0);
    rst_n = 1'b1;

    // Directed corner operands, issued back-to-back.
    for (int i = 0; i < 8; i++) drive(dir_a[i], dir_b[i], dir_s[i]);
    drain();

    // A request arriving mid-operation must be ignored.
    drive(32'hFFFF_FFF0, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_not_ready", 64'(bus32.ready), 64'd0);
    bus32.valid_in = 1'b1;
    bus32.a = 32'd9;
    bus32.b = 32'd9;
    bus32.signed_mode = 1'b0;
    @(negedge clk);
    bus32.valid_in = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Randomized traffic with varying operand bit lengths and idle gaps.
    for (int i = 0; i < 150; i++) begin
      bl    = $urandom_range(0, 32);
      mask  = (bl == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - bl));
      rnd_a = $urandom & mask;
      rnd_b = $urandom;
      drive(rnd_a, rnd_b, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
    drain();

    // Reset in the middle of a long operation discards it.
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midop_reset_r", bus32.r, 64'd0);
    check("midop_reset_ready", 64'(bus32.ready), 64'd1);
    check("midop_reset_valid_out", 64'(bus32.valid_out), 64'd0);
    repeat (12) @(negedge clk);

    // 16-bit, radix-2 instance: unsigned 0xFFFF * 2 takes 8 edges in either build.
    bus16.valid_in = 1'b1;
    bus16.a = 16'hFFFF;
    bus16.b = 16'h0002;
    bus16.signed_mode = 1'b0;
    check("w16_ready", 64'(bus16.ready), 64'd1);
    @(posedge clk);
    #1;
    cap16 = cyc;
    bus16.valid_in = 1'b0;
    n16 = 0;
    while (!bus16.valid_out && n16 < 50) begin
      @(negedge clk);
      n16++;
    end
    check("w16_valid_out_seen", 64'(bus16.valid_out), 64'd1);
    check("w16_product", 64'(bus16.r), 64'h0000_0000_0001_FFFE);
    check("w16_latency", 64'(cyc - cap16), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
